// File: rtl/gpu_axi_pkg.sv
// Shared definitions for the GPU AXI initiator.
// Contents:
//   state_t        - FSM state encoding
//   SIZE_4B        - AxSIZE for a 32-bit beat
//   BURST_INCR     - AxBURST encoding for INCR
//   RESP_OKAY      - xRESP encoding for OKAY
//   DEFAULT_AXI_ID - ID used when the instantiating engine does not override it
package gpu_axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WADDR = 3'd1,
        ST_WRESP = 3'd2,
        ST_RADDR = 3'd3,
        ST_RDATA = 3'd4,
        ST_RESP  = 3'd5
    } state_t;

    localparam logic [2:0] SIZE_4B        = 3'b010;
    localparam logic [1:0] BURST_INCR     = 2'b01;
    localparam logic [1:0] RESP_OKAY      = 2'b00;
    localparam logic [3:0] DEFAULT_AXI_ID = 4'h1;

endpackage

// File: rtl/gpu_axi_master.sv
// Single-outstanding AXI initiator: converts the GPU request/response bus into
// one-beat 32-bit AXI reads or strobed writes.
//
// Ports:
//   aclk, areset            clock, synchronous active-high reset
//   req_*                   GPU request (valid/ready, wen=0 means read, addr, wdata)
//   resp_*                  GPU response (valid/ready, rdata, err)
//   m_aw*, m_w*, m_b*       AXI write address / data / response channels
//   m_ar*, m_r*             AXI read address / data channels
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | req_ready high, waiting for a request
// ST_WADDR | AW and W beats offered, each dropped on its own handshake
// ST_WRESP | bready high, waiting for the write response
// ST_RADDR | arvalid high, waiting for arready
// ST_RDATA | rready high, waiting for the read beat
// ST_RESP  | resp_valid high, waiting for resp_ready
module gpu_axi_master
    import gpu_axi_pkg::*;
#(
    parameter logic [3:0] AXI_ID = DEFAULT_AXI_ID,
    parameter int         ADDR_W = 32
) (
    input  logic              aclk,
    input  logic              areset,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_wen,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,

    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,

    output logic [3:0]        m_awid,
    output logic [ADDR_W-1:0] m_awaddr,
    output logic [7:0]        m_awlen,
    output logic [2:0]        m_awsize,
    output logic [1:0]        m_awburst,
    output logic              m_awlock,
    output logic [3:0]        m_awcache,
    output logic [2:0]        m_awprot,
    output logic              m_awvalid,
    input  logic              m_awready,

    output logic [3:0]        m_wid,
    output logic [31:0]       m_wdata,
    output logic [3:0]        m_wstrb,
    output logic              m_wlast,
    output logic              m_wvalid,
    input  logic              m_wready,

    input  logic [3:0]        m_bid,
    input  logic [1:0]        m_bresp,
    input  logic              m_bvalid,
    output logic              m_bready,

    output logic [3:0]        m_arid,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [7:0]        m_arlen,
    output logic [2:0]        m_arsize,
    output logic [1:0]        m_arburst,
    output logic              m_arlock,
    output logic [3:0]        m_arcache,
    output logic [2:0]        m_arprot,
    output logic              m_arvalid,
    input  logic              m_arready,

    input  logic [3:0]        m_rid,
    input  logic [31:0]       m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rlast,
    input  logic              m_rvalid,
    output logic              m_rready
);

    state_t            state;
    logic              aw_done;
    logic              w_done;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        wen_q;
    logic [31:0]       wdata_q;

    logic aw_hs;
    logic w_hs;
    assign aw_hs = m_awvalid && m_awready;
    assign w_hs  = m_wvalid && m_wready;

    // Only the SLVERR/DECERR bit of xRESP matters; EXOKAY is treated as success.
    logic unused_bits;
    assign unused_bits = ^{req_addr[1:0], m_bresp[0], m_rresp[0]};

    // Address/data/strobe come straight from the request latch, so they stay
    // stable for the whole life of the transaction.
    assign m_awid    = AXI_ID;
    assign m_awaddr  = addr_q;
    assign m_awlen   = 8'd0;
    assign m_awsize  = SIZE_4B;
    assign m_awburst = BURST_INCR;
    assign m_awlock  = 1'b0;
    assign m_awcache = 4'd0;
    assign m_awprot  = 3'd0;

    assign m_wid     = AXI_ID;
    assign m_wdata   = wdata_q;
    assign m_wstrb   = wen_q;
    assign m_wlast   = 1'b1;

    assign m_arid    = AXI_ID;
    assign m_araddr  = addr_q;
    assign m_arlen   = 8'd0;
    assign m_arsize  = SIZE_4B;
    assign m_arburst = BURST_INCR;
    assign m_arlock  = 1'b0;
    assign m_arcache = 4'd0;
    assign m_arprot  = 3'd0;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state      <= ST_IDLE;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            addr_q     <= '0;
            wen_q      <= 4'd0;
            wdata_q    <= 32'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
            m_awvalid  <= 1'b0;
            m_wvalid   <= 1'b0;
            m_bready   <= 1'b0;
            m_arvalid  <= 1'b0;
            m_rready   <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_q    <= {req_addr[ADDR_W-1:2], 2'b00};
                        wen_q     <= req_wen;
                        wdata_q   <= req_wdata;
                        req_ready <= 1'b0;
                        if (req_wen != 4'b0000) begin
                            state     <= ST_WADDR;
                            m_awvalid <= 1'b1;
                            m_wvalid  <= 1'b1;
                        end else begin
                            state     <= ST_RADDR;
                            m_arvalid <= 1'b1;
                        end
                    end
                end
                ST_WADDR: begin
                    if (aw_hs) begin
                        m_awvalid <= 1'b0;
                        aw_done   <= 1'b1;
                    end
                    if (w_hs) begin
                        m_wvalid <= 1'b0;
                        w_done   <= 1'b1;
                    end
                    // Completion counts a handshake happening this very cycle,
                    // so simultaneous AW/W acceptance moves on without a bubble.
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        state    <= ST_WRESP;
                        m_bready <= 1'b1;
                        aw_done  <= 1'b0;
                        w_done   <= 1'b0;
                    end
                end
                ST_WRESP: begin
                    if (m_bvalid) begin
                        state      <= ST_RESP;
                        m_bready   <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_rdata <= 32'd0;
                        resp_err   <= m_bresp[1] | (m_bid != AXI_ID);
                    end
                end
                ST_RADDR: begin
                    if (m_arready) begin
                        state     <= ST_RDATA;
                        m_arvalid <= 1'b0;
                        m_rready  <= 1'b1;
                    end
                end
                ST_RDATA: begin
                    if (m_rvalid) begin
                        state      <= ST_RESP;
                        m_rready   <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_rdata <= m_rdata;
                        resp_err   <= m_rresp[1] | (m_rid != AXI_ID) | !m_rlast;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state      <= ST_IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpu_axi_master.sv
// Directed bench for gpu_axi_master: a behavioural AXI slave with per-channel
// ready delays, a response scoreboard fed by the stimulus, and a monitor that
// pops and compares on every response handshake.
module tb_gpu_axi_master;
    import gpu_axi_pkg::*;

    localparam logic [3:0] ID = 4'h1;

    logic        aclk = 1'b0;
    logic        areset;
    logic        req_valid, req_ready;
    logic [3:0]  req_wen;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic [3:0]  m_awid, m_wid, m_arid;
    logic [31:0] m_awaddr, m_araddr, m_wdata;
    logic [7:0]  m_awlen, m_arlen;
    logic [2:0]  m_awsize, m_arsize, m_awprot, m_arprot;
    logic [1:0]  m_awburst, m_arburst;
    logic        m_awlock, m_arlock;
    logic [3:0]  m_awcache, m_arcache, m_wstrb;
    logic        m_awvalid, m_wvalid, m_wlast, m_bready, m_arvalid, m_rready;
    logic        m_awready = 1'b0, m_wready = 1'b0, m_arready = 1'b0;
    logic [3:0]  m_bid = 4'h0, m_rid = 4'h0;
    logic [1:0]  m_bresp = 2'b00, m_rresp = 2'b00;
    logic        m_bvalid = 1'b0, m_rvalid = 1'b0, m_rlast = 1'b0;
    logic [31:0] m_rdata = 32'h0;

    always #5 aclk = ~aclk;

    gpu_axi_master #(.AXI_ID(ID), .ADDR_W(32)) dut (
        .aclk(aclk), .areset(areset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
        .m_awburst(m_awburst), .m_awlock(m_awlock), .m_awcache(m_awcache),
        .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wid(m_wid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arlock(m_arlock), .m_arcache(m_arcache),
        .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t exp_q[$];
    int   n_resp    = 0;
    int   exp_total = 0;

    // slave configuration (written by stimulus only)
    int          aw_dly = 0, w_dly = 0, ar_dly = 0;
    logic [3:0]  s_bid = ID, s_rid = ID;
    logic [1:0]  s_bresp = 2'b00, s_rresp = 2'b00;
    logic        s_rlast = 1'b1;
    logic [31:0] s_rdata = 32'h0;

    // slave observations (written by the slave process only)
    int          cyc = 0, aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
    int          n_aw = 0, n_w = 0, n_ar = 0, n_b = 0, n_r = 0;
    int          aw_hs_cyc = 0, w_hs_cyc = 0, ar_held = 0, ar_unstable = 0;
    logic [31:0] ar_addr0 = 32'h0, aw_addr_cap = 32'h0, w_data_cap = 32'h0;
    logic [3:0]  w_strb_cap = 4'h0;
    logic        aw_seen = 1'b0, w_seen = 1'b0, b_pend = 1'b0, b_hs = 1'b0;
    logic        r_pend = 1'b0, r_hs = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // AXI slave. A handshake is recognised at the negedge where valid and ready
    // are both high; it completes at the following posedge.
    always @(negedge aclk) begin
        cyc++;
        if (areset) begin
            m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0;
            m_bvalid = 1'b0; m_rvalid = 1'b0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
            aw_seen = 1'b0; w_seen = 1'b0; b_pend = 1'b0; b_hs = 1'b0;
            r_pend = 1'b0; r_hs = 1'b0;
        end else begin
            if (b_hs) begin m_bvalid = 1'b0; b_hs = 1'b0; n_b++; end
            if (b_pend && !m_bvalid) begin
                m_bvalid = 1'b1; m_bid = s_bid; m_bresp = s_bresp; b_pend = 1'b0;
            end
            if (m_bvalid && m_bready) b_hs = 1'b1;

            if (r_hs) begin m_rvalid = 1'b0; r_hs = 1'b0; n_r++; end
            if (r_pend && !m_rvalid) begin
                m_rvalid = 1'b1; m_rid = s_rid; m_rdata = s_rdata;
                m_rresp = s_rresp; m_rlast = s_rlast; r_pend = 1'b0;
            end
            if (m_rvalid && m_rready) r_hs = 1'b1;

            if (m_awvalid) begin aw_cnt++; m_awready = (aw_cnt > aw_dly); end
            else begin aw_cnt = 0; m_awready = 1'b0; end
            if (m_awvalid && m_awready) begin
                n_aw++; aw_seen = 1'b1; aw_hs_cyc = cyc; aw_addr_cap = m_awaddr;
            end

            if (m_wvalid) begin w_cnt++; m_wready = (w_cnt > w_dly); end
            else begin w_cnt = 0; m_wready = 1'b0; end
            if (m_wvalid && m_wready) begin
                n_w++; w_seen = 1'b1; w_hs_cyc = cyc; w_data_cap = m_wdata; w_strb_cap = m_wstrb;
            end

            if (aw_seen && w_seen) begin b_pend = 1'b1; aw_seen = 1'b0; w_seen = 1'b0; end

            if (m_arvalid) begin
                ar_cnt++;
                if (ar_cnt == 1) ar_addr0 = m_araddr;
                else if (m_araddr != ar_addr0) ar_unstable++;
                m_arready = (ar_cnt > ar_dly);
            end else begin
                ar_cnt = 0; m_arready = 1'b0;
            end
            if (m_arvalid && m_arready) begin n_ar++; ar_held = ar_cnt; r_pend = 1'b1; end
        end
    end

    // response monitor / scoreboard
    always @(negedge aclk) begin
        if (resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL resp_unexpected: got rdata 0x%08h err %0b, expected no response",
                         resp_rdata, resp_err);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("resp_rdata", resp_rdata, e.rdata);
                check("resp_err", {31'b0, resp_err}, {31'b0, e.err});
            end
            n_resp++;
        end
    end

    task automatic issue(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rd, input logic exp_err);
        bit ok;
        ok = 1'b0;
        @(posedge aclk); #1;
        req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge aclk);
            ok = req_ready;
        end
        if (!ok) begin
            n_tests++; n_fail++;
            $display("FAIL req_accept_timeout: got req_ready 0, expected 1 within 50 cycles");
        end else begin
            exp_q.push_back(exp_t'{exp_rd, exp_err});
            exp_total++;
        end
        @(posedge aclk); #1;
        req_valid = 1'b0; req_wen = 4'hA; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5555_5555;
    endtask

    task automatic wait_resp(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge aclk);
            done = (n_resp >= exp_total);
        end
        if (!done) begin
            n_tests++; n_fail++;
            $display("FAIL %s_timeout: got %0d responses, expected %0d", name, n_resp, exp_total);
        end
        repeat (2) @(negedge aclk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b_aw, b_w, b_b, b_ar, b_r, rv_at, bad;
        areset = 1'b1; req_valid = 1'b0; req_wen = 4'h0; req_addr = 32'h0;
        req_wdata = 32'h0; resp_ready = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_err", {31'b0, resp_err}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_valids", {27'b0, m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 32'd0);
        @(posedge aclk); #1 areset = 1'b0;

        // zero-wait write
        b_aw = n_aw; b_w = n_w; b_b = n_b;
        issue(4'hF, 32'h1C00_0010, 32'hDEAD_BEEF, 32'h0, 1'b0);
        @(negedge aclk);
        check("wr_awvalid", {31'b0, m_awvalid}, 32'd1);
        check("wr_wvalid", {31'b0, m_wvalid}, 32'd1);
        check("wr_awaddr", m_awaddr, 32'h1C00_0010);
        check("wr_wstrb", {28'b0, m_wstrb}, 32'hF);
        check("wr_wlast", {31'b0, m_wlast}, 32'd1);
        check("wr_wdata", m_wdata, 32'hDEAD_BEEF);
        check("wr_awid", {28'b0, m_awid}, {28'b0, ID});
        check("wr_awsize_len_burst", {19'b0, m_awsize, m_awlen, m_awburst}, {19'b0, 3'b010, 8'd0, 2'b01});
        rv_at = 0;
        for (int n = 1; n <= 20 && rv_at == 0; n++) begin
            if (n > 1) @(negedge aclk);
            if (resp_valid) rv_at = n;
        end
        check("wr_latency", rv_at, 32'd3);
        wait_resp("wr0");
        check("wr0_aw_beats", n_aw - b_aw, 32'd1);
        check("wr0_w_beats", n_w - b_w, 32'd1);
        check("wr0_b_beats", n_b - b_b, 32'd1);
        check("wr0_same_cycle", aw_hs_cyc - w_hs_cyc, 32'd0);

        // read, arready delayed so arvalid is held 5 cycles
        ar_dly = 4; s_rdata = 32'h1234_5678;
        b_ar = n_ar; b_r = n_r;
        issue(4'h0, 32'h1C00_0106, 32'h0, 32'h1234_5678, 1'b0);
        wait_resp("rd0");
        check("rd0_ar_held", ar_held, 32'd5);
        check("rd0_ar_stable", ar_unstable, 32'd0);
        check("rd0_araddr", ar_addr0, 32'h1C00_0104);
        check("rd0_ar_beats", n_ar - b_ar, 32'd1);
        check("rd0_r_beats", n_r - b_r, 32'd1);
        ar_dly = 0;

        // W accepted 4 cycles before AW
        aw_dly = 4; w_dly = 0;
        b_aw = n_aw; b_w = n_w; b_b = n_b;
        issue(4'b0101, 32'h0000_0040, 32'hA5A5_0F0F, 32'h0, 1'b0);
        wait_resp("wr_wfirst");
        check("wfirst_order", aw_hs_cyc - w_hs_cyc, 32'd4);
        check("wfirst_aw_beats", n_aw - b_aw, 32'd1);
        check("wfirst_w_beats", n_w - b_w, 32'd1);
        check("wfirst_b_beats", n_b - b_b, 32'd1);
        check("wfirst_wdata", w_data_cap, 32'hA5A5_0F0F);
        check("wfirst_wstrb", {28'b0, w_strb_cap}, 32'h5);

        // AW accepted 4 cycles before W
        aw_dly = 0; w_dly = 4;
        b_aw = n_aw; b_w = n_w; b_b = n_b;
        issue(4'b1000, 32'h0000_0083, 32'h0102_0304, 32'h0, 1'b0);
        wait_resp("wr_awfirst");
        check("awfirst_order", w_hs_cyc - aw_hs_cyc, 32'd4);
        check("awfirst_aw_beats", n_aw - b_aw, 32'd1);
        check("awfirst_w_beats", n_w - b_w, 32'd1);
        check("awfirst_b_beats", n_b - b_b, 32'd1);
        check("awfirst_awaddr", aw_addr_cap, 32'h0000_0080);
        w_dly = 0;

        // error paths
        s_bresp = 2'b10;
        issue(4'h3, 32'h0000_0100, 32'h1111_2222, 32'h0, 1'b1);
        wait_resp("err_bresp");
        s_bresp = 2'b00;
        s_rid = ID + 4'h1; s_rdata = 32'h0BAD_0001;
        issue(4'h0, 32'h0000_0200, 32'h0, 32'h0BAD_0001, 1'b1);
        wait_resp("err_rid");
        s_rid = ID;
        s_rlast = 1'b0; s_rdata = 32'h0BAD_0002;
        issue(4'h0, 32'h0000_0204, 32'h0, 32'h0BAD_0002, 1'b1);
        wait_resp("err_rlast");
        s_rlast = 1'b1;
        s_rresp = 2'b11; s_rdata = 32'h0BAD_0003;
        issue(4'h0, 32'h0000_0208, 32'h0, 32'h0BAD_0003, 1'b1);
        wait_resp("err_rresp");
        s_rresp = 2'b00;

        // response back-pressure for 10 cycles, with a competing request
        @(posedge aclk); #1 resp_ready = 1'b0;
        s_rdata = 32'hCAFE_F00D;
        issue(4'h0, 32'h3000_0008, 32'h0, 32'hCAFE_F00D, 1'b0);
        rv_at = 0;
        for (int i = 0; i < 50 && rv_at == 0; i++) begin
            @(negedge aclk);
            if (resp_valid) rv_at = 1;
        end
        check("hold_resp_seen", rv_at, 32'd1);
        @(posedge aclk); #1;
        req_valid = 1'b1; req_wen = 4'b0011; req_addr = 32'h2000_0007; req_wdata = 32'h0000_BEEF;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge aclk);
            if (!resp_valid || resp_rdata !== 32'hCAFE_F00D || resp_err !== 1'b0 || req_ready !== 1'b0)
                bad++;
        end
        check("hold_stable_cycles_bad", bad, 32'd0);
        exp_q.push_back(exp_t'{32'h0, 1'b0});
        exp_total++;
        @(posedge aclk); #1 resp_ready = 1'b1;
        @(negedge aclk);
        check("hold_req_ready_at_hs", {31'b0, req_ready}, 32'd0);
        @(negedge aclk);
        check("hold_req_ready_after", {31'b0, req_ready}, 32'd1);
        @(posedge aclk); #1;
        req_valid = 1'b0; req_wen = 4'h0; req_addr = 32'h0; req_wdata = 32'h0;
        @(negedge aclk);
        check("hold_next_awaddr", m_awaddr, 32'h2000_0004);
        check("hold_next_wstrb", {28'b0, m_wstrb}, 32'h3);
        wait_resp("hold_next");

        // reset while AW/W are outstanding
        aw_dly = 20; w_dly = 20;
        issue(4'hF, 32'h1000_0000, 32'h7777_7777, 32'h0, 1'b0);
        @(negedge aclk);
        check("rst_mid_awvalid_before", {31'b0, m_awvalid}, 32'd1);
        @(posedge aclk); #1 areset = 1'b1;
        @(posedge aclk); #1 areset = 1'b0;
        exp_q.delete();
        exp_total = n_resp;
        @(negedge aclk);
        check("rst_mid_valids", {27'b0, m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 32'd0);
        check("rst_mid_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_mid_resp_valid", {31'b0, resp_valid}, 32'd0);
        aw_dly = 0; w_dly = 0;
        b_ar = n_ar;
        s_rdata = 32'h600D_F00D;
        issue(4'h0, 32'h1000_0020, 32'h0, 32'h600D_F00D, 1'b0);
        wait_resp("rst_recover");
        check("rst_recover_ar_beats", n_ar - b_ar, 32'd1);

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
